// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared command/reply byte constants and handler state type
package uart_cmd_pkg;

    localparam logic [7:0] CMD_WRITE   = 8'h77;
    localparam logic [7:0] CMD_READ    = 8'h72;
    localparam logic [7:0] CMD_STROBE  = 8'h74;
    localparam logic [7:0] CMD_VERSION = 8'h76;

    localparam logic [7:0] RSP_ACK = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_MASK,
        ST_REPLY
    } state_e;

endpackage

// File: rtl/uart_reply_seq.sv
// rtl/uart_reply_seq.sv - reply byte buffer paced against the transmitter busy flag
module uart_reply_seq #(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [CNT_W-1:0]   count_i,
    input  logic [DEPTH*8-1:0] data_i,
    input  logic               tx_busy_i,
    output logic [7:0]         tx_data_o,
    output logic               tx_en_o,
    output logic               done_o
);

    logic [DEPTH*8-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]   remain_q, remain_d;
    logic               active_q, active_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_en_q;
    logic               fire;

    // Holding off while tx_en_q is high covers the cycle before busy rises.
    assign fire   = active_q && (remain_q != '0) && !tx_busy_i && !tx_en_q;
    assign done_o = active_q && tx_en_q && (remain_q == '0);

    always_comb begin
        buf_d     = buf_q;
        remain_d  = remain_q;
        active_d  = active_q;
        tx_data_d = tx_data_q;
        if (load_i) begin
            buf_d    = data_i;
            remain_d = count_i;
            active_d = 1'b1;
        end else begin
            if (fire) begin
                tx_data_d = buf_q[7:0];
                buf_d     = buf_q >> 8;
                remain_d  = remain_q - CNT_W'(1);
            end
            if (done_o) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q     <= '0;
            remain_q  <= '0;
            active_q  <= 1'b0;
            tx_data_q <= '0;
            tx_en_q   <= 1'b0;
        end else begin
            buf_q     <= buf_d;
            remain_q  <= remain_d;
            active_q  <= active_d;
            tx_data_q <= tx_data_d;
            tx_en_q   <= fire;
        end
    end

    assign tx_data_o = tx_data_q;
    assign tx_en_o   = tx_en_q;

endmodule

// File: rtl/uart_reg_handler.sv
// rtl/uart_reg_handler.sv - byte-stream command decoder driving a generic register file
module uart_reg_handler
    import uart_cmd_pkg::*;
#(
    parameter int         NUM_REGS       = 8,
    parameter int         REG_BYTES      = 2,
    parameter int         NUM_STROBES    = 4,
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter logic [7:0] VERSION        = 8'h02
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [7:0]                      rx_data_i,
    input  logic                            rx_valid_i,
    output logic [7:0]                      tx_data_o,
    output logic                            tx_en_o,
    input  logic                            tx_busy_i,
    output logic [NUM_REGS*REG_BYTES*8-1:0] regs_o,
    output logic [NUM_STROBES-1:0]          strobe_o,
    output logic                            timeout_o,
    output logic                            overrun_o
);

    localparam int W     = REG_BYTES * 8;
    localparam int DEPTH = (REG_BYTES > 2) ? REG_BYTES : 2;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int BC_W  = 3;
    localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : TW'(TIMEOUT_CYCLES - 1);

    state_e              state_q, state_d;
    logic [7:0]          cmd_q, cmd_d;
    logic [7:0]          addr_q, addr_d;
    logic [BC_W-1:0]     bc_q, bc_d;
    logic [W-1:0]        stage_q, stage_d, stage_nx;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [NUM_STROBES-1:0] strobe_q, strobe_d;
    logic                timeout_q, timeout_d;
    logic                overrun_q, overrun_d;
    logic [W-1:0]        regs_q [NUM_REGS];
    logic [W-1:0]        rd_word;
    logic [DEPTH*8-1:0]  rd_bytes;
    logic                wr_en;
    logic                rd_ok, wr_ok, in_cmd, tmo_hit;
    logic                load;
    logic [CNT_W-1:0]    load_cnt;
    logic [DEPTH*8-1:0]  load_data;
    logic                reply_done;

    assign rd_ok    = ({1'b0, rx_data_i} < 9'(NUM_REGS));
    assign wr_ok    = ({1'b0, addr_q} < 9'(NUM_REGS));
    assign in_cmd   = (state_q == ST_ADDR) || (state_q == ST_DATA) || (state_q == ST_MASK);
    assign tmo_hit  = (TIMEOUT_CYCLES != 0) && in_cmd && !rx_valid_i && (tmo_q == TMO_LAST);
    assign stage_nx = W'({stage_q, rx_data_i});

    // Read-back bytes are queued with the register MSB sent first.
    always_comb begin
        rd_word  = '0;
        rd_bytes = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rx_data_i == 8'(k)) rd_word = regs_q[k];
        end
        for (int i = 0; i < REG_BYTES; i++) begin
            rd_bytes[i*8 +: 8] = rd_word[(REG_BYTES-1-i)*8 +: 8];
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        bc_d      = bc_q;
        stage_d   = stage_q;
        strobe_d  = '0;
        timeout_d = 1'b0;
        overrun_d = 1'b0;
        wr_en     = 1'b0;
        load      = 1'b0;
        load_cnt  = '0;
        load_data = '0;
        tmo_d     = (!in_cmd || rx_valid_i) ? '0 : tmo_q + TW'(1);

        case (state_q)
            ST_IDLE: begin
                if (rx_valid_i) begin
                    cmd_d = rx_data_i;
                    case (rx_data_i)
                        CMD_WRITE, CMD_READ: state_d = ST_ADDR;
                        CMD_STROBE:          state_d = ST_MASK;
                        CMD_VERSION: begin
                            load            = 1'b1;
                            load_cnt        = CNT_W'(2);
                            load_data[7:0]  = VERSION;
                            load_data[15:8] = 8'(NUM_REGS);
                            state_d         = ST_REPLY;
                        end
                        default: begin
                            load           = 1'b1;
                            load_cnt       = CNT_W'(1);
                            load_data[7:0] = rx_data_i;
                            state_d        = ST_REPLY;
                        end
                    endcase
                end
            end
            ST_ADDR: begin
                if (rx_valid_i) begin
                    addr_d = rx_data_i;
                    if (cmd_q == CMD_WRITE) begin
                        bc_d    = BC_W'(REG_BYTES - 1);
                        stage_d = '0;
                        state_d = ST_DATA;
                    end else begin
                        load    = 1'b1;
                        state_d = ST_REPLY;
                        if (rd_ok) begin
                            load_cnt  = CNT_W'(REG_BYTES);
                            load_data = rd_bytes;
                        end else begin
                            load_cnt       = CNT_W'(1);
                            load_data[7:0] = RSP_ERR;
                        end
                    end
                end else if (tmo_hit) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (rx_valid_i) begin
                    stage_d = stage_nx;
                    if (bc_q == '0) begin
                        wr_en          = wr_ok;
                        load           = 1'b1;
                        load_cnt       = CNT_W'(1);
                        load_data[7:0] = wr_ok ? RSP_ACK : RSP_ERR;
                        state_d        = ST_REPLY;
                    end else begin
                        bc_d = bc_q - BC_W'(1);
                    end
                end else if (tmo_hit) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_MASK: begin
                if (rx_valid_i) begin
                    strobe_d       = rx_data_i[NUM_STROBES-1:0];
                    load           = 1'b1;
                    load_cnt       = CNT_W'(1);
                    load_data[7:0] = RSP_ACK;
                    state_d        = ST_REPLY;
                end else if (tmo_hit) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_REPLY: begin
                overrun_d = rx_valid_i;
                if (reply_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cmd_q     <= '0;
            addr_q    <= '0;
            bc_q      <= '0;
            stage_q   <= '0;
            tmo_q     <= '0;
            strobe_q  <= '0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            bc_q      <= bc_d;
            stage_q   <= stage_d;
            tmo_q     <= tmo_d;
            strobe_q  <= strobe_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
            for (int k = 0; k < NUM_REGS; k++) begin
                if (wr_en && (addr_q == 8'(k))) regs_q[k] <= stage_nx;
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
        assign regs_o[k*W +: W] = regs_q[k];
    end

    uart_reply_seq #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_reply_seq (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .count_i   (load_cnt),
        .data_i    (load_data),
        .tx_busy_i (tx_busy_i),
        .tx_data_o (tx_data_o),
        .tx_en_o   (tx_en_o),
        .done_o    (reply_done)
    );

    assign strobe_o  = strobe_q;
    assign timeout_o = timeout_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_uart_reg_handler.sv
// tb/tb_uart_reg_handler.sv - directed bench for uart_reg_handler with a busy-pacing tx model
module tb_uart_reg_handler;

    localparam int BUSY_LEN = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   rx_data_i = '0;
    logic         rx_valid_i = 1'b0;
    logic [7:0]   tx_data_o;
    logic         tx_en_o;
    logic         tx_busy_i = 1'b0;
    logic [127:0] regs_o;
    logic [3:0]   strobe_o;
    logic         timeout_o;
    logic         overrun_o;

    int n_checks = 0;
    int n_pass   = 0;
    int busy_cnt = 0;
    int busy_viol = 0;
    int dbl_viol = 0;
    int n_timeout = 0;
    int n_overrun = 0;
    logic prev_en = 1'b0;
    logic [7:0] tx_q[$];
    int t0, o0;

    uart_reg_handler #(
        .NUM_REGS       (8),
        .REG_BYTES      (2),
        .NUM_STROBES    (4),
        .TIMEOUT_CYCLES (20),
        .VERSION        (8'h02)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .tx_data_o  (tx_data_o),
        .tx_en_o    (tx_en_o),
        .tx_busy_i  (tx_busy_i),
        .regs_o     (regs_o),
        .strobe_o   (strobe_o),
        .timeout_o  (timeout_o),
        .overrun_o  (overrun_o)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy rises right after each accepted pulse.
    always @(negedge clk) begin
        if (tx_en_o) begin
            tx_q.push_back(tx_data_o);
            if (tx_busy_i) busy_viol++;
            if (prev_en) dbl_viol++;
            tx_busy_i = 1'b1;
            busy_cnt  = BUSY_LEN;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) tx_busy_i = 1'b0;
        end
        prev_en = tx_en_o;
        if (timeout_o) n_timeout++;
        if (overrun_o) n_overrun++;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [8:0] txb(input int i);
        return (i < tx_q.size()) ? {1'b0, tx_q[i]} : 9'h1FF;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        @(negedge clk);
        rx_valid_i = 1'b0;
    endtask

    task automatic wait_tx(input string tag, input int n);
        int cyc = 0;
        while (tx_q.size() < n && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        repeat (15) @(negedge clk);
        check(tag, tx_q.size(), n);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_regs", regs_o, '0);
        check("reset_tx_en", tx_en_o, 0);
        check("reset_tx_data", tx_data_o, 0);
        check("reset_strobe", strobe_o, 0);
        check("reset_timeout", timeout_o, 0);
        check("reset_overrun", overrun_o, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        tx_q.delete();
        send_byte(8'h77); send_byte(8'h03); send_byte(8'h12);
        check("write_before_last", regs_o, '0);
        send_byte(8'h34);
        check("write_reg3", regs_o, 128'h1234 << 48);
        wait_tx("write_tx_count", 1);
        check("write_ack", txb(0), 9'h04B);

        tx_q.delete();
        send_byte(8'h72); send_byte(8'h03);
        wait_tx("read_tx_count", 2);
        check("read_msb", txb(0), 9'h012);
        check("read_lsb", txb(1), 9'h034);

        tx_q.delete();
        send_byte(8'h77); send_byte(8'h08); send_byte(8'hAA); send_byte(8'hBB);
        wait_tx("bad_write_count", 1);
        check("bad_write_err", txb(0), 9'h045);
        check("bad_write_regs", regs_o, 128'h1234 << 48);

        tx_q.delete();
        send_byte(8'h72); send_byte(8'h09);
        wait_tx("bad_read_count", 1);
        check("bad_read_err", txb(0), 9'h045);

        tx_q.delete();
        send_byte(8'h74); send_byte(8'hF5);
        check("strobe_pulse", strobe_o, 4'h5);
        @(negedge clk);
        check("strobe_clear", strobe_o, 4'h0);
        wait_tx("strobe_tx_count", 1);
        check("strobe_ack", txb(0), 9'h04B);

        tx_q.delete();
        t0 = n_timeout;
        send_byte(8'h77); send_byte(8'h01); send_byte(8'h55);
        repeat (40) @(negedge clk);
        check("timeout_pulses", n_timeout - t0, 1);
        check("timeout_no_tx", tx_q.size(), 0);
        check("timeout_no_write", regs_o, 128'h1234 << 48);
        send_byte(8'h76);
        wait_tx("version_count", 2);
        check("version_byte", txb(0), 9'h002);
        check("version_nregs", txb(1), 9'h008);

        tx_q.delete();
        o0 = n_overrun;
        @(negedge clk);
        rx_data_i = 8'h41; rx_valid_i = 1'b1;
        @(negedge clk);
        rx_data_i = 8'h42;
        @(negedge clk);
        rx_valid_i = 1'b0;
        wait_tx("echo_count", 1);
        check("echo_byte", txb(0), 9'h041);
        check("overrun_pulses", n_overrun - o0, 1);

        tx_q.delete();
        send_byte(8'h72); send_byte(8'h03);
        begin
            int cyc = 0;
            while (tx_q.size() < 1 && cyc < 100) begin
                @(negedge clk);
                cyc++;
            end
        end
        rst = 1'b1;
        @(negedge clk);
        check("rst_tx_en", tx_en_o, 0);
        check("rst_regs", regs_o, '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("rst_abort_tx", tx_q.size(), 1);
        check("rst_first_byte", txb(0), 9'h012);

        check("busy_respected", busy_viol, 0);
        check("no_double_pulse", dbl_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
